mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified memory port between the pipeline's fetch requester (IF) and load/store requester (LS).
//  Sits between the IF/ID and execute/wb stages and the single memory model; replaces separate imem/dmem paths.
//  Fixed priority LS > IF, grant locked across back-pressure, in-order response routing via a source-tag FIFO.
// PARAMETERS
//  ADDR_W          32  address width
//  DATA_W          32  data width; strobe width is DATA_W/8
//  MAX_OUTSTANDING 2   accepted-but-unanswered requests allowed (tag FIFO depth, power of 2, >=1)
//  STARVE_LIMIT    4   consecutive LS grants with IF waiting before IF is forced (ARB_STARVE_GUARD_EN only)
// PORTS
//  clk            in  1         clock, all state on rising edge
//  reset          in  1         asynchronous, active-low reset
//  if_req_valid   in  1         fetch request
//  if_req_ready   out 1         fetch request accepted this cycle
//  if_req_addr    in  ADDR_W    fetch address
//  if_rsp_valid   out 1         fetch response
//  if_rsp_data    out DATA_W    fetched instruction
//  ls_req_valid   in  1         load/store request
//  ls_req_ready   out 1         load/store accepted this cycle
//  ls_req_addr    in  ADDR_W    load/store address
//  ls_req_we      in  1         1 = store
//  ls_req_wdata   in  DATA_W    store data
//  ls_req_wstrb   in  DATA_W/8  store byte enables
//  ls_rsp_valid   out 1         load data / store ack
//  ls_rsp_data    out DATA_W    load data (don't-care for store ack)
//  mem_req_valid  out 1         request to memory
//  mem_req_ready  in  1         memory accepts
//  mem_req_addr/we/wdata/wstrb out ADDR_W/1/DATA_W/DATA_W/8  muxed request fields
//  mem_rsp_valid  in  1         memory response, in request order, one per accepted request (stores included)
//  mem_rsp_data   in  DATA_W    response data
//  err_orphan_rsp out 1         sticky: mem_rsp_valid seen with tag FIFO empty
// BEHAVIOUR
//  Reset: all outputs 0, lock=NONE, tag FIFO empty, starve count 0, err_orphan_rsp 0.
//  Handshake: valid/ready; transfer when both high. Requester must hold fields stable while valid && !ready.
//  can_issue = (count < MAX_OUTSTANDING); count-based only, so a same-cycle pop does not free a slot (no rsp->ready path).
//  Lock FSM: NONE -> LS_LOCK / IF_LOCK when mem_req_valid && !mem_req_ready; lock returns to NONE on mem_req_ready.
//   While locked, the locked source owns the port regardless of the other valid.
//  Winner in NONE: LS if ls_req_valid, else IF if if_req_valid; none -> mem_req_valid 0.
//  Request mux is combinational (0-cycle): mem_req_valid = winner valid && can_issue; winner ready = mem_req_ready && can_issue;
//   loser ready = 0. IF path drives we=0, wstrb=0, wdata=0.
//  On mem transfer: push winner source tag. On mem_rsp_valid: pop head, route data combinationally to that source's rsp
//   (0-cycle); other rsp_valid = 0. Push and pop in same cycle: count unchanged.
//  mem_rsp_valid with FIFO empty: response dropped, err_orphan_rsp set until reset.
//  Pointers wrap modulo MAX_OUTSTANDING; count is $clog2(MAX_OUTSTANDING)+1 bits, saturates never (push gated by can_issue).
//  Reset mid-transaction: FIFO and lock cleared instantly; memory is reset in the same domain, late responses count as orphans.
// CONFIGURATION
//  ARB_STARVE_GUARD_EN defined: counter increments on each LS grant while if_req_valid is high, clears on any IF grant
//   or when IF not waiting; at count == STARVE_LIMIT the NONE-state winner is IF even if LS valid.
//  Undefined: strict LS > IF priority, IF may starve indefinitely; STARVE_LIMIT unused.
// STRUCTURE
//  Package mem_arb_pkg: typedef enum logic [1:0] {LOCK_NONE, LOCK_IF, LOCK_LS} lock_e;
//   typedef enum logic {SRC_IF, SRC_LS} src_e.
//  Sub-module arb_tag_fifo (DEPTH, src_e payload, push/pop/count/head) holds outstanding source tags.
// TESTING
//  Both valid same cycle, mem_req_ready=1, latency 1 -> LS granted first, IF next cycle; rsp to ls then if in order.
//  LS valid, mem_req_ready held 0 for 3 cycles, IF rises cycle 1 -> lock stays LS, IF ready 0 until LS transfer.
//  MAX_OUTSTANDING=2, memory withholds responses -> 3rd request sees ready 0; one rsp pops, next cycle ready 1.
//  Store wstrb=4'b0011 addr 0x40 -> mem_req_we=1, wstrb 0011; ack rsp appears on ls_rsp_valid only.
//  mem_rsp_valid pulse with no outstanding requests -> no rsp_valid asserted, err_orphan_rsp=1 until reset low.
//  ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, LS and IF always valid -> 4 LS grants, then 1 IF grant, pattern repeats.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  // Which requester currently owns a stalled memory request
  typedef enum logic [1:0] {LOCK_NONE, LOCK_IF, LOCK_LS} lock_e;

  // Source tag carried through the response-order FIFO
  typedef enum logic {SRC_IF, SRC_LS} src_e;

  // Pointer width that stays legal for a single-entry FIFO
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order store of source tags for outstanding memory requests.
// Latency: push visible at head one cycle later; head/count are registered.
// Backpressure: none internally; caller gates push on count < DEPTH and pop on count != 0.
module arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  src_e                     i_push_src,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_count,
  output src_e                     o_head
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  src_e             r_slot [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Tag storage and write pointer; pointers wrap at DEPTH, not at 2**PTR_W
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_slot[i] <= SRC_IF;
      r_wr_ptr <= '0;
    end else if (i_push) begin
      r_slot[r_wr_ptr] <= i_push_src;
      r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on each pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
    end else if (i_pop) begin
      r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_slot[r_rd_ptr];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (LS), LS has priority.
// Latency: 0-cycle request mux and 0-cycle response routing; ordering tracked by a tag FIFO.
// Backpressure: stalled grant is locked until accepted; no new issue once MAX_OUTSTANDING are in flight.
// Optional feature macro ARB_STARVE_GUARD_EN: forces an IF grant after STARVE_LIMIT LS grants with IF waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic                ls_req_we,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                err_orphan_rsp
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Elaboration-time sanity checks on the configuration
  if (MAX_OUTSTANDING < 1 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
    $error("mem_port_arbiter: MAX_OUTSTANDING must be a power of 2 and >= 1");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
  end

  lock_e            r_lock;
  lock_e            w_lock_nxt;
  logic             w_ls_win;
  logic             w_if_win;
  logic             w_can_issue;
  logic             w_mem_xfer;
  logic             w_pop;
  logic             w_fifo_empty;
  logic             w_starve_force;
  logic [CNT_W-1:0] w_count;
  src_e             w_head;
  logic             r_err;

  // Issue slots are counted before this cycle's pop, so a response never frees a slot combinationally
  assign w_can_issue  = (w_count < CNT_W'(MAX_OUTSTANDING));
  assign w_mem_xfer   = mem_req_valid && mem_req_ready;
  assign w_fifo_empty = (w_count == '0);
  assign w_pop        = mem_rsp_valid && !w_fifo_empty;

  // Lock state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lock <= LOCK_NONE;
    else        r_lock <= w_lock_nxt;
  end

  // Lock next state: take the lock on a stalled request, release it when the request is accepted
  always_comb begin
    w_lock_nxt = r_lock;
    case (r_lock)
      LOCK_NONE: begin
        if (mem_req_valid && !mem_req_ready) w_lock_nxt = w_ls_win ? LOCK_LS : LOCK_IF;
      end
      default: begin
        if (w_mem_xfer) w_lock_nxt = LOCK_NONE;
      end
    endcase
  end

  // Winner selection and request mux; the IF path never writes
  always_comb begin
    w_ls_win      = 1'b0;
    w_if_win      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    case (r_lock)
      LOCK_LS: w_ls_win = 1'b1;
      LOCK_IF: w_if_win = 1'b1;
      default: begin
        if (w_starve_force && if_req_valid) w_if_win = 1'b1;
        else if (ls_req_valid)              w_ls_win = 1'b1;
        else if (if_req_valid)              w_if_win = 1'b1;
      end
    endcase
    if (w_ls_win) begin
      mem_req_valid = ls_req_valid && w_can_issue;
      mem_req_addr  = ls_req_addr;
      mem_req_we    = ls_req_we;
      mem_req_wdata = ls_req_wdata;
      mem_req_wstrb = ls_req_wstrb;
    end else if (w_if_win) begin
      mem_req_valid = if_req_valid && w_can_issue;
      mem_req_addr  = if_req_addr;
    end
    ls_req_ready = w_ls_win && mem_req_ready && w_can_issue;
    if_req_ready = w_if_win && mem_req_ready && w_can_issue;
  end

  arb_tag_fifo #(
    .DEPTH      (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_mem_xfer),
    .i_push_src (w_ls_win ? SRC_LS : SRC_IF),
    .i_pop      (w_pop),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  // Route each response to the source at the head of the tag FIFO
  always_comb begin
    ls_rsp_valid = w_pop && (w_head == SRC_LS);
    if_rsp_valid = w_pop && (w_head == SRC_IF);
    ls_rsp_data  = ls_rsp_valid ? mem_rsp_data : '0;
    if_rsp_data  = if_rsp_valid ? mem_rsp_data : '0;
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           r_err <= 1'b0;
    else if (mem_rsp_valid && w_fifo_empty) r_err <= 1'b1;
  end

  assign err_orphan_rsp = r_err;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] r_starve_cnt;

  // Count LS grants taken while IF waits; any IF grant or IF going idle resets it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (!if_req_valid || (w_mem_xfer && w_if_win)) begin
      r_starve_cnt <= '0;
    end else if (w_mem_xfer && w_ls_win && !w_starve_force) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_starve_force = (r_starve_cnt == SC_W'(STARVE_LIMIT));
`else
  assign w_starve_force = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of priority, lock, outstanding limit, store, starvation and orphan handling.
// Latency: inputs driven 1ns after posedge, outputs checked at negedge.
// Backpressure: the bench plays the memory and drives mem_req_ready / mem_rsp_valid directly.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_data;
  logic [3:0]  ls_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;
  logic        err_orphan_rsp;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_req_we(ls_req_we), .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .err_orphan_rsp(err_orphan_rsp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = 0;
    ls_req_valid = 0; ls_req_addr = 0; ls_req_we = 0; ls_req_wdata = 0; ls_req_wstrb = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    #2;
    n_cmp++;
    if ({mem_req_valid, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, err_orphan_rsp} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 000000",
               {mem_req_valid, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, err_orphan_rsp});
    end
    tick();
    reset = 1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (err_orphan_rsp !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b required 0", err_orphan_rsp);
    end
  endtask

  task automatic test_priority();
    tick();
    ls_req_valid = 1; ls_req_addr = 32'h200; ls_req_we = 0;
    if_req_valid = 1; if_req_addr = 32'h100; mem_req_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b110 || mem_req_addr !== 32'h200) begin
      n_bad++; $display("FAIL prio_ls_first: got v/lr/ir %b addr %h required 110 addr 200",
                        {mem_req_valid, ls_req_ready, if_req_ready}, mem_req_addr);
    end
    tick();
    ls_req_valid = 0; ls_req_we = 1; ls_req_wdata = 32'hFFFF_FFFF; ls_req_wstrb = 4'hF;
    mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA_0001;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b101 ||
        {mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata} !== {32'h100, 1'b0, 4'h0, 32'h0}) begin
      n_bad++; $display("FAIL prio_if_next: got v/lr/ir %b addr %h we %b strb %h wdata %h required 101 100 0 0 0",
                        {mem_req_valid, ls_req_ready, if_req_ready}, mem_req_addr, mem_req_we,
                        mem_req_wstrb, mem_req_wdata);
    end
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid} !== 2'b10 || ls_rsp_data !== 32'hAAAA_0001) begin
      n_bad++; $display("FAIL prio_rsp_ls: got lv/iv %b data %h required 10 AAAA0001",
                        {ls_rsp_valid, if_rsp_valid}, ls_rsp_data);
    end
    tick();
    if_req_valid = 0; ls_req_we = 0; ls_req_wdata = 0; ls_req_wstrb = 0; mem_rsp_data = 32'hBBBB_0002;
    @(negedge clk);
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid, mem_req_valid} !== 3'b010 || if_rsp_data !== 32'hBBBB_0002) begin
      n_bad++; $display("FAIL prio_rsp_if: got lv/iv/mv %b data %h required 010 BBBB0002",
                        {ls_rsp_valid, if_rsp_valid, mem_req_valid}, if_rsp_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lock();
    // LS stalls, IF arrives: LS keeps the port
    ls_req_valid = 1; ls_req_addr = 32'h300;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b100 || mem_req_addr !== 32'h300) begin
        n_bad++; $display("FAIL lock_ls_hold c%0d: got v/lr/ir %b addr %h required 100 addr 300",
                          c, {mem_req_valid, ls_req_ready, if_req_ready}, mem_req_addr);
      end
      tick();
      if_req_valid = 1; if_req_addr = 32'h104;
    end
    mem_req_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b110) begin
      n_bad++; $display("FAIL lock_ls_release: got %b required 110", {mem_req_valid, ls_req_ready, if_req_ready});
    end
    tick();
    ls_req_valid = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b101 || mem_req_addr !== 32'h104) begin
      n_bad++; $display("FAIL lock_if_after: got %b addr %h required 101 addr 104",
                        {mem_req_valid, ls_req_ready, if_req_ready}, mem_req_addr);
    end
    tick();
    if_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1;
    tick();
    tick();
    mem_rsp_valid = 0;
    // IF stalls, LS arrives: IF keeps the port despite LS priority
    if_req_valid = 1; if_req_addr = 32'h108;
    tick();
    ls_req_valid = 1; ls_req_addr = 32'h304;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b100 || mem_req_addr !== 32'h108) begin
      n_bad++; $display("FAIL lock_if_hold: got %b addr %h required 100 addr 108",
                        {mem_req_valid, ls_req_ready, if_req_ready}, mem_req_addr);
    end
    tick();
    mem_req_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready, if_req_ready} !== 3'b101 || mem_req_addr !== 32'h108) begin
      n_bad++; $display("FAIL lock_if_release: got %b addr %h required 101 addr 108",
                        {mem_req_valid, ls_req_ready, if_req_ready}, mem_req_addr);
    end
    tick();
    if_req_valid = 0;
    tick();
    ls_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1;
    @(negedge clk);
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid} !== 2'b01) begin
      n_bad++; $display("FAIL lock_rsp_order0: got %b required 01", {ls_rsp_valid, if_rsp_valid});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL lock_rsp_order1: got %b required 10", {ls_rsp_valid, if_rsp_valid});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_outstanding();
    ls_req_valid = 1; mem_req_ready = 1;
    for (int k = 0; k < 2; k++) begin
      ls_req_addr = 32'h10 + 32'(4 * k);
      @(negedge clk);
      n_cmp++;
      if (ls_req_ready !== 1'b1) begin
        n_bad++; $display("FAIL outst_accept%0d: got %b required 1", k, ls_req_ready);
      end
      tick();
    end
    ls_req_addr = 32'h18;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, ls_req_ready} !== 2'b00) begin
      n_bad++; $display("FAIL outst_full: got v/r %b required 00", {mem_req_valid, ls_req_ready});
    end
    tick();
    mem_rsp_valid = 1;
    @(negedge clk);
    n_cmp++;
    if ({ls_req_ready, ls_rsp_valid} !== 2'b01) begin
      n_bad++; $display("FAIL outst_pop_same_cycle: got r/rsp %b required 01", {ls_req_ready, ls_rsp_valid});
    end
    tick();
    mem_rsp_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (ls_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL outst_freed: got %b required 1", ls_req_ready);
    end
    tick();
    ls_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({ls_rsp_valid, if_rsp_valid} !== 2'b10) begin
        n_bad++; $display("FAIL outst_drain%0d: got %b required 10", k, {ls_rsp_valid, if_rsp_valid});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_store();
    ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 32'h40; ls_req_wdata = 32'hDEAD_BEEF;
    ls_req_wstrb = 4'b0011; mem_req_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata} !==
        {1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL store_req: got v %b we %b strb %b addr %h wdata %h required 1 1 0011 40 DEADBEEF",
                        mem_req_valid, mem_req_we, mem_req_wstrb, mem_req_addr, mem_req_wdata);
    end
    tick();
    idle_inputs();
    mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678;
    @(negedge clk);
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL store_ack: got lv/iv %b required 10", {ls_rsp_valid, if_rsp_valid});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starve();
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    prev_g = 2'b00;
    tick();
    ls_req_valid = 1; ls_req_addr = 32'h500; if_req_valid = 1; if_req_addr = 32'h600; mem_req_ready = 1;
    for (int i = 0; i < 15; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_g = (i % 5 == 4) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      @(negedge clk);
      n_cmp++;
      if ({ls_req_ready, if_req_ready} !== exp_g) begin
        n_bad++; $display("FAIL starve_grant%0d: got lr/ir %b required %b", i, {ls_req_ready, if_req_ready}, exp_g);
      end
      if (i > 0) begin
        n_cmp++;
        if ({ls_rsp_valid, if_rsp_valid} !== prev_g) begin
          n_bad++; $display("FAIL starve_rsp%0d: got lv/iv %b required %b", i, {ls_rsp_valid, if_rsp_valid}, prev_g);
        end
      end
      prev_g = exp_g;
      tick();
      mem_rsp_valid = 1;
    end
    ls_req_valid = 0; if_req_valid = 0; mem_req_ready = 0;
    @(negedge clk);
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid} !== prev_g) begin
      n_bad++; $display("FAIL starve_rsp_last: got %b required %b", {ls_rsp_valid, if_rsp_valid}, prev_g);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_orphan();
    // Request accepted, then reset before its response: the late response is an orphan
    ls_req_valid = 1; ls_req_addr = 32'h700; mem_req_ready = 1;
    @(negedge clk);
    n_cmp++;
    if (ls_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL orphan_setup: got %b required 1", ls_req_ready);
    end
    tick();
    idle_inputs();
    reset = 0;
    tick();
    reset = 1;
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_0000;
    @(negedge clk);
    n_cmp++;
    if ({ls_rsp_valid, if_rsp_valid, err_orphan_rsp} !== 3'b000) begin
      n_bad++; $display("FAIL orphan_drop: got lv/iv/err %b required 000", {ls_rsp_valid, if_rsp_valid, err_orphan_rsp});
    end
    tick();
    mem_rsp_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (err_orphan_rsp !== 1'b1) begin
      n_bad++; $display("FAIL orphan_set: got %b required 1", err_orphan_rsp);
    end
    tick();
    tick();
    @(negedge clk);
    n_cmp++;
    if (err_orphan_rsp !== 1'b1) begin
      n_bad++; $display("FAIL orphan_sticky: got %b required 1", err_orphan_rsp);
    end
    reset = 0;
    #1;
    n_cmp++;
    if (err_orphan_rsp !== 1'b0) begin
      n_bad++; $display("FAIL orphan_clear: got %b required 0", err_orphan_rsp);
    end
    tick();
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_outstanding();
    test_store();
    test_starve();
    test_orphan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
